// File: rtl/ecall_run_ctrl.sv
// ecall_run_ctrl: run controller for the single-cycle RISC-V core.
// It gates commit (cpu_en) around ecall I/O traps and debounces the
// continue button. It also issues the one-cycle strobes that latch switch
// input into a0 (io_in_we) or show a0 on the display (io_out_en).
//
// Optional feature macro: SINGLE_STEP_EN. When defined it adds the step_mode
// input, and RUN then commits one non-ecall instruction per debounced press.
module ecall_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ecall,
  input  logic [1:0] ecall_code,
  input  logic       continue_button,
`ifdef SINGLE_STEP_EN
  input  logic       step_mode,
`endif
  output logic       cpu_en,
  output logic       io_in_we,
  output logic       io_out_en,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RUN          = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    COMMIT       = 3'd3,
    HALT         = 3'd4
  } state_e;

  localparam logic [1:0] CODE_READ  = 2'd0;
  localparam logic [1:0] CODE_PRINT = 2'd1;
  localparam logic [1:0] CODE_EXIT  = 2'd2;

  // Last counter value before the debounced level flips.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Button synchronizer and debouncer
  // ---------------------------------------------------------------------
  logic [1:0]       sync_q;
  logic             btn_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             btn_db_prev_q;
  logic             press;

  assign btn_s = sync_q[1];

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], continue_button};
  end

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      btn_db_d = ~btn_db_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers; the previous level is kept for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
    end
  end

  // press is high for one cycle, in the first cycle btn_db_q is high.
  assign press = btn_db_q & ~btn_db_prev_q;

  // ---------------------------------------------------------------------
  // Optional single-step gating
  // ---------------------------------------------------------------------
  logic step_ok;

`ifdef SINGLE_STEP_EN
  logic [1:0] step_sync_q;

  // Synchronize the step_mode switch before it gates commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_sync_q <= 2'b00;
    else       step_sync_q <= {step_sync_q[0], step_mode};
  end

  assign step_ok = ~step_sync_q[1] | press;
`else
  assign step_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Run FSM
  // ---------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic       io_out_q, io_out_d;
  logic       cpu_en_c;
  logic       io_in_c;

  // Next state, ecall code latch and combinational commit/strobe outputs.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    io_out_d = 1'b0;
    cpu_en_c = 1'b0;
    io_in_c  = 1'b0;
    case (state_q)
      RUN: begin
        // The ecall is held back here and retires later, in COMMIT.
        cpu_en_c = ~ecall & step_ok;
        if (ecall) begin
          code_d = ecall_code;
          case (ecall_code)
            CODE_READ:  state_d = WAIT_PRESS;
            CODE_PRINT: begin
              state_d  = WAIT_PRESS;
              io_out_d = 1'b1;
            end
            CODE_EXIT:  state_d = HALT;
            default:    state_d = COMMIT;
          endcase
        end
      end
      WAIT_PRESS: begin
        if (press) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Wait for release so that one long hold cannot serve two ecalls.
        if (!btn_db_q) state_d = COMMIT;
      end
      COMMIT: begin
        cpu_en_c = 1'b1;
        io_in_c  = (code_q == CODE_READ);
        state_d  = RUN;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM state, latched ecall code and the registered display strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      code_q   <= 2'b00;
      io_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      io_out_q <= io_out_d;
    end
  end

  assign cpu_en    = cpu_en_c;
  assign io_in_we  = io_in_c;
  assign io_out_en = io_out_q;
  assign halted    = (state_q == HALT);
  assign state     = state_q;

endmodule

// File: tb/tb_ecall_run_ctrl.sv
// Bench for ecall_run_ctrl with DEBOUNCE_CYCLES=4. Strobe and commit events
// are predicted into a queue and a negedge monitor pops and compares them.
module tb_ecall_run_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       ecall;
  logic [1:0] ecall_code;
  logic       continue_button;
`ifdef SINGLE_STEP_EN
  logic       step_mode;
`endif
  logic       cpu_en, io_in_we, io_out_en, halted;
  logic [2:0] state;

  ecall_run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .ecall(ecall), .ecall_code(ecall_code),
    .continue_button(continue_button),
`ifdef SINGLE_STEP_EN
    .step_mode(step_mode),
`endif
    .cpu_en(cpu_en), .io_in_we(io_in_we), .io_out_en(io_out_en),
    .halted(halted), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       out;
    logic       in_we;
    logic       cpu;
    logic [2:0] st;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  // Monitor: any strobe or a COMMIT cycle is an event that must be predicted.
  always @(negedge clock) begin
    if (!reset && (io_out_en || io_in_we || state == 3'd3)) begin
      ev_t got, want;
      got = '{out: io_out_en, in_we: io_in_we, cpu: cpu_en, st: state};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL event: unexpected out=%0b in_we=%0b cpu=%0b st=%0d",
                 got.out, got.in_we, got.cpu, got.st);
      end else begin
        want = exp_q.pop_front();
        if (got == want) passes++;
        else $display("FAIL event: got out=%0b in_we=%0b cpu=%0b st=%0d, want out=%0b in_we=%0b cpu=%0b st=%0d",
                      got.out, got.in_we, got.cpu, got.st,
                      want.out, want.in_we, want.cpu, want.st);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  // One clock; the core model retires the ecall (drops it) once COMMIT is seen.
  task automatic tick();
    @(posedge clock);
    #1;
    if (state == 3'd3) ecall = 1'b0;
  endtask

  task automatic btn(input int hi, input int lo);
    continue_button = 1'b1;
    repeat (hi) tick();
    continue_button = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic start_ecall(input logic [1:0] code);
    ecall      = 1'b1;
    ecall_code = code;
  endtask

  initial begin
    int n;
    reset = 1'b1; ecall = 1'b0; ecall_code = 2'd0; continue_button = 1'b0;
`ifdef SINGLE_STEP_EN
    step_mode = 1'b0;
`endif
    // Reset values
    @(negedge clock);
    chk("rst_state", state, 0);
    chk("rst_cpu_en", cpu_en, 1);
    chk("rst_strobes", {io_out_en, io_in_we}, 0);
    chk("rst_halted", halted, 0);
    tick(); reset = 1'b0;

    // Free run: commit every cycle
    n = 0;
    repeat (6) begin tick(); @(negedge clock); if (cpu_en && state == 3'd0) n++; end
    chk("freerun_commits", n, 6);

    // Print: display strobe then one commit; code change mid-wait ignored
    exp_q.push_back('{out: 1'b1, in_we: 1'b0, cpu: 1'b0, st: 3'd1});
    exp_q.push_back('{out: 1'b0, in_we: 1'b0, cpu: 1'b1, st: 3'd3});
    start_ecall(2'd1);
    @(negedge clock);
    chk("print_decode_cpu_en", cpu_en, 0);
    tick();
    ecall_code = 2'd0;
    btn(10, 12);
    chk("print_back_to_run", state, 0);

    // Read: io_in_we coincides with the single commit
    exp_q.push_back('{out: 1'b0, in_we: 1'b1, cpu: 1'b1, st: 3'd3});
    start_ecall(2'd0);
    tick();
    chk("read_wait_state", state, 1);
    btn(6, 12);
    chk("read_back_to_run", state, 0);

    // Glitchy button during WAIT_PRESS must not produce press
    start_ecall(2'd0);
    tick();
    repeat (5) btn(2, 1);
    @(negedge clock);
    chk("glitch_state", state, 1);
    exp_q.push_back('{out: 1'b0, in_we: 1'b1, cpu: 1'b1, st: 3'd3});
    continue_button = 1'b1;
    repeat (8) tick();
    chk("clean_press_state", state, 2);
    continue_button = 1'b0;
    repeat (12) tick();
    chk("glitch_back_to_run", state, 0);

    // No-op ecall goes straight to COMMIT
    exp_q.push_back('{out: 1'b0, in_we: 1'b0, cpu: 1'b1, st: 3'd3});
    start_ecall(2'd3);
    tick();
    tick();
    chk("noop_back_to_run", state, 0);

    // A press in RUN is discarded and does not satisfy a later ecall
    n = 0;
    continue_button = 1'b1;
    repeat (8) begin tick(); @(negedge clock); if (cpu_en) n++; end
    continue_button = 1'b0;
    repeat (10) begin tick(); @(negedge clock); if (cpu_en) n++; end
    chk("run_press_commits", n, 18);
    start_ecall(2'd0);
    repeat (6) tick();
    chk("run_press_not_queued", state, 1);
    exp_q.push_back('{out: 1'b0, in_we: 1'b1, cpu: 1'b1, st: 3'd3});
    btn(8, 12);
    chk("queued_back_to_run", state, 0);

    // Reset while waiting abandons the ecall
    exp_q.push_back('{out: 1'b1, in_we: 1'b0, cpu: 1'b0, st: 3'd1});
    start_ecall(2'd1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midwait_rst_state", state, 0);
    chk("midwait_rst_strobes", {io_out_en, io_in_we}, 0);
    ecall = 1'b0;
    tick(); reset = 1'b0;

    // Exit: halted for 1000 cycles despite presses
    start_ecall(2'd2);
    tick();
    chk("halt_state", state, 4);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      continue_button = ((i % 20) < 10);
      tick();
      @(negedge clock);
      if (halted && !cpu_en && state == 3'd4) n++;
    end
    chk("halt_held_cycles", n, 1000);
    continue_button = 1'b0;
    reset = 1'b1;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_state", state, 0);
    ecall = 1'b0;
    tick(); tick(); reset = 1'b0;

`ifdef SINGLE_STEP_EN
    // Single step: one commit per clean press
    step_mode = 1'b1;
    repeat (4) tick();
    n = 0;
    repeat (3) begin
      continue_button = 1'b1;
      repeat (8) begin tick(); @(negedge clock); if (cpu_en) n++; end
      continue_button = 1'b0;
      repeat (8) begin tick(); @(negedge clock); if (cpu_en) n++; end
    end
    chk("step_commits", n, 3);
    step_mode = 1'b0;
`endif

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
